// File: rtl/bruteforce_candidate_gen.sv
// bruteforce_candidate_gen: odometer-style password candidate enumerator.
// Each accepted candidate advances position 0 by the programmed stride; carries
// ripple left by one, and a carry past the top active position grows the length.
// Optional compare-and-stop against a target is enabled by defining BF_MATCH_EN.
module bruteforce_candidate_gen #(
  parameter int unsigned MAX_LEN  = 16,
  parameter logic [7:0]  CHAR_MIN = 8'h61,
  parameter logic [7:0]  CHAR_MAX = 8'h7A,
  parameter int unsigned STRIDE_W = 3,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [7:0]                    start_char,
  input  logic [STRIDE_W-1:0]           increment,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [8*MAX_LEN-1:0]          password,
  output logic [$clog2(MAX_LEN+1)-1:0]  cand_len,
  output logic [CNT_W-1:0]              cand_count,
  output logic                          busy,
  output logic                          done
`ifdef BF_MATCH_EN
  ,
  input  logic [8*MAX_LEN-1:0]          target,
  output logic                          found
`endif
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                    state, state_n;
  logic [MAX_LEN-1:0][7:0]   pos_q, pos_nxt, pos_load;
  logic [LEN_W-1:0]          len_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [STRIDE_W-1:0]       inc_q;
  logic [8:0]                stride;
  logic [8:0]                sum;
  logic [7:0]                first_char;
  logic                      carry;
  logic                      grow;
  logic                      exhaust;
  logic                      accept;
  logic                      hit;

  assign password   = pos_q;
  assign cand_len   = len_q;
  assign cand_count = cnt_q;

  // Out-of-range start characters fall back to the bottom of the range.
  always_comb begin
    first_char = start_char;
    if ((start_char < CHAR_MIN) || (start_char > CHAR_MAX)) first_char = CHAR_MIN;
    pos_load    = '0;
    pos_load[0] = first_char;
  end

  // Odometer step: stride on position 0, +1 on carried positions, grow or exhaust on top carry.
  always_comb begin
    stride  = (inc_q == '0) ? 9'd1 : 9'(inc_q);
    pos_nxt = pos_q;
    carry   = 1'b1;
    grow    = 1'b0;
    sum     = '0;
    for (int unsigned k = 0; k < MAX_LEN; k++) begin
      if (k < 32'(len_q)) begin
        if (carry) begin
          sum = {1'b0, pos_q[k]} + ((k == 0) ? stride : 9'd1);
          if (sum > {1'b0, CHAR_MAX}) begin
            pos_nxt[k] = CHAR_MIN;
            carry      = 1'b1;
          end else begin
            pos_nxt[k] = sum[7:0];
            carry      = 1'b0;
          end
        end
      end else if ((k == 32'(len_q)) && carry) begin
        pos_nxt[k] = CHAR_MIN;
        grow       = 1'b1;
        carry      = 1'b0;
      end
    end
    exhaust = carry;
  end

  // Target comparison against the currently presented candidate.
  always_comb begin
`ifdef BF_MATCH_EN
    hit = (password == target);
`else
    hit = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next state and status outputs; start always wins, including mid-run.
  always_comb begin
    state_n   = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        accept    = out_ready && !start;
        if (accept && (hit || exhaust)) state_n = ST_DONE;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
    if (start) state_n = ST_RUN;
  end

  // Candidate datapath: load on start, advance only on accept, freeze on match/exhaustion.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      inc_q <= '0;
    end else if (start) begin
      pos_q <= pos_load;
      len_q <= LEN_W'(1);
      cnt_q <= '0;
      inc_q <= increment;
    end else if (accept) begin
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      if (!hit && !exhaust) begin
        pos_q <= pos_nxt;
        if (grow) len_q <= len_q + LEN_W'(1);
      end
    end
  end

`ifdef BF_MATCH_EN
  // Match flag: set on accepting the target, cleared by reset or a new start.
  always_ff @(posedge clk) begin
    if (reset || start)       found <= 1'b0;
    else if (accept && hit)   found <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bruteforce_candidate_gen.sv
// Testbench for bruteforce_candidate_gen: queue-based reference model feeds a
// scoreboard; a negedge monitor compares every presented candidate.
// Define BF_MATCH_EN to also exercise the target-match stop.
module tb_bruteforce_candidate_gen;

  typedef bit [7:0] bq_t[$];
  typedef struct {
    logic [127:0] pw;
    int           len;
    int           cnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, start, out_ready;
  logic [7:0]   start_char;
  logic [2:0]   increment;
  logic         out_valid, busy, done;
  logic [127:0] password;
  logic [4:0]   cand_len;
  logic [31:0]  cand_count;

  logic         s_start, s_ready, s_valid, s_busy, s_done;
  logic [7:0]   s_char;
  logic [2:0]   s_inc;
  logic [15:0]  s_pw;
  logic [1:0]   s_len;
  logic [2:0]   s_cnt;
`ifdef BF_MATCH_EN
  logic [127:0] target;
  logic         found;
  logic         s_found;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t me;

  always #5 clk = ~clk;

  bruteforce_candidate_gen #(
    .MAX_LEN(16), .CHAR_MIN(8'h61), .CHAR_MAX(8'h7A), .STRIDE_W(3), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_char(start_char),
    .increment(increment), .out_valid(out_valid), .out_ready(out_ready),
    .password(password), .cand_len(cand_len), .cand_count(cand_count),
    .busy(busy), .done(done)
`ifdef BF_MATCH_EN
    , .target(target), .found(found)
`endif
  );

  bruteforce_candidate_gen #(
    .MAX_LEN(2), .CHAR_MIN(8'h61), .CHAR_MAX(8'h63), .STRIDE_W(3), .CNT_W(3)
  ) sdut (
    .clk(clk), .reset(reset), .start(s_start), .start_char(s_char),
    .increment(s_inc), .out_valid(s_valid), .out_ready(s_ready),
    .password(s_pw), .cand_len(s_len), .cand_count(s_cnt),
    .busy(s_busy), .done(s_done)
`ifdef BF_MATCH_EN
    , .target(16'h0000), .found(s_found)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Candidate as a queue of characters, index 0 = rightmost; returns the successor.
  function automatic void model_adv(input bq_t qi, input int inc, input int cmin, input int cmax,
                                    input int maxlen, output bq_t qo, output bit exh);
    int s;
    int v;
    qo  = qi;
    exh = 1'b0;
    s   = (inc == 0) ? 1 : inc;
    for (int k = 0; k < qo.size(); k++) begin
      v = int'(qo[k]) + ((k == 0) ? s : 1);
      if (v <= cmax) begin
        qo[k] = 8'(v);
        return;
      end
      qo[k] = 8'(cmin);
    end
    if (qo.size() < maxlen) qo.push_back(8'(cmin));
    else begin
      exh = 1'b1;
      qo  = qi;
    end
  endfunction

  function automatic logic [127:0] pack(input bq_t q);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < q.size(); i++) p[8*i +: 8] = q[i];
    return p;
  endfunction

  task automatic push_seq(input logic [7:0] sc, input int inc, input int n);
    bq_t  q, q2;
    bit   exh;
    exp_t e;
    q.delete();
    q.push_back((sc < 8'h61 || sc > 8'h7A) ? 8'h61 : sc);
    for (int i = 0; i < n; i++) begin
      e.pw  = pack(q);
      e.len = q.size();
      e.cnt = i;
      exp_q.push_back(e);
      model_adv(q, inc, 'h61, 'h7A, 16, q2, exh);
      if (exh) break;
      q = q2;
    end
  endtask

  // Scoreboard monitor: every presented candidate is compared; popped on accept.
  always @(negedge clk) begin
    if (!reset && !start && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got candidate 0x%0h, expected none", password);
      end else begin
        me = exp_q[0];
        chk("sb_password", password, me.pw);
        chk("sb_cand_len", 128'(cand_len), 128'(me.len));
        chk("sb_cand_count", 128'(cand_count), 128'(me.cnt));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_start(input logic [7:0] sc, input logic [2:0] inc, input int n_exp);
    @(posedge clk); #1;
    start      = 1'b1;
    start_char = sc;
    increment  = inc;
    exp_q.delete();
    push_seq(sc, int'(inc), n_exp);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_accepts(input int n, input int pct);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 20 * n + 50) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(99) < pct);
      @(negedge clk);
      if (out_valid && out_ready) acc++;
      cyc++;
    end
    if (acc < n) chk("accept_timeout", 128'(acc), 128'(n));
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic small_test();
    bq_t          sq, sq2;
    bit           sexh;
    int           acc;
    logic [127:0] sp;
    s_ready = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b1; s_char = 8'h61; s_inc = 3'd1;
    @(posedge clk); #1;
    s_start = 1'b0;
    sq.delete();
    sq.push_back(8'h61);
    acc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (s_done) break;
      if (s_valid) begin
        sp = pack(sq);
        chk("small_pw", 128'(s_pw), 128'(sp[15:0]));
        chk("small_cnt_sat", 128'(s_cnt), 128'((acc > 7) ? 7 : acc));
        acc++;
        model_adv(sq, 1, 'h61, 'h63, 2, sq2, sexh);
        if (!sexh) sq = sq2;
      end
    end
    chk("small_accepts", 128'(acc), 128'(12));
    chk("small_done", 128'(s_done), 128'(1));
    chk("small_valid_off", 128'(s_valid), 128'(0));
    chk("small_last_pw", 128'(s_pw), 128'(16'h6363));
    chk("small_cnt_final", 128'(s_cnt), 128'(7));
    s_ready = 1'b0;
    @(posedge clk); #1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    @(negedge clk);
    chk("small_restart_valid", 128'(s_valid), 128'(1));
    chk("small_restart_done", 128'(s_done), 128'(0));
    chk("small_restart_cnt", 128'(s_cnt), 128'(0));
    chk("small_restart_pw", 128'(s_pw), 128'(16'h0061));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_password"}, password, 128'(0));
    chk({tag, "_len"}, 128'(cand_len), 128'(0));
    chk({tag, "_count"}, 128'(cand_count), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; start_char = 8'h00; increment = 3'd0;
    s_start = 1'b0; s_ready = 1'b0; s_char = 8'h00; s_inc = 3'd0;
`ifdef BF_MATCH_EN
    target = '0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // "a".."z","aa","ab" then backpressure, then single accept
    do_start(8'h61, 3'd1, 60);
    run_accepts(28, 100);
    @(negedge clk);
    chk("t2_count", 128'(cand_count), 128'(28));
    chk("t2_password", password, 128'(16'h6163));
    repeat (5) @(negedge clk);
    chk("t4_hold_count", 128'(cand_count), 128'(28));
    chk("t4_hold_password", password, 128'(16'h6163));
    run_accepts(1, 100);
    @(negedge clk);
    chk("t4_one_step", password, 128'(16'h6164));
    chk("t4_count", 128'(cand_count), 128'(29));

    // stride 3 from "x" wraps straight into length 2
    do_start(8'h78, 3'd3, 10);
    run_accepts(2, 100);
    @(negedge clk);
    chk("t3_password", password, 128'(16'h6164));
    chk("t3_busy", 128'(busy), 128'(1));
    do_start(8'h61, 3'd0, 10);
    run_accepts(2, 100);
    @(negedge clk);
    chk("t3_inc0", password, 128'(8'h63));

    // reset in the middle of a run
    do_start(8'h61, 3'd1, 50);
    run_accepts(5, 100);
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_zero("t1");
    out_ready = 1'b0;

    // randomized runs, including out-of-range start chars and aborts with out_ready high
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(10, 60);
      if (it % 3 == 2) out_ready = 1'b1;
      do_start(8'($urandom_range(8'h58, 8'h80)), 3'($urandom_range(0, 7)), n + 8);
      run_accepts(n, 60);
    end

    // long run crossing into length 3
    do_start(8'h61, 3'd7, 240);
    run_accepts(230, 100);
    @(negedge clk);
    chk("long_len3", 128'(cand_len), 128'(3));

    small_test();

`ifdef BF_MATCH_EN
    target = 128'(16'h6162);
    do_start(8'h61, 3'd1, 40);
    run_accepts(28, 100);
    @(negedge clk);
    chk("t6_found", 128'(found), 128'(1));
    chk("t6_done", 128'(done), 128'(1));
    chk("t6_valid", 128'(out_valid), 128'(0));
    chk("t6_password", password, 128'(16'h6162));
    chk("t6_count", 128'(cand_count), 128'(28));
    do_start(8'h61, 3'd1, 5);
    @(negedge clk);
    chk("t6_found_clear", 128'(found), 128'(0));
    target = '0;
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
